// File: rtl/param_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Optional PARAM_DIVIDER_FAST_ERR_EN: overflow/divide-by-zero cases finish one cycle after accept.
module param_divider #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               overflow,
    output logic               div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [WIDTH:0]     r_reg;
    logic [WIDTH-1:0]   shift_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic [WIDTH-1:0]   divisor_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [CW-1:0]      cnt_reg;
    logic               ovf_reg;
    logic               dz_reg;

    logic [WIDTH-1:0]   quotient_reg;
    logic [WIDTH-1:0]   remainder_reg;
    logic               overflow_reg;
    logic               div_by_zero_reg;

    logic               accept;
    logic               err_in;
    logic               dz_in;
    logic               last_step;
    logic [WIDTH:0]     r_shift;
    logic               fits;
    logic [WIDTH:0]     r_step;
    logic [WIDTH-1:0]   q_step;

    // A quotient wider than WIDTH bits is exactly the case where the high half already reaches the divisor.
    assign dz_in     = (divisor == '0);
    assign err_in    = (dividend[2*WIDTH-1:WIDTH] >= divisor);
    assign accept    = start && (state_reg != CALC);
    assign last_step = (cnt_reg == CW'(WIDTH - 1));

    // One restoring step: bring down the next dividend bit, subtract when it fits.
    always_comb begin
        r_shift = {r_reg[WIDTH-1:0], shift_reg[WIDTH-1]};
        fits    = (r_shift >= {1'b0, divisor_reg});
        r_step  = fits ? (r_shift - {1'b0, divisor_reg}) : r_shift;
        q_step  = {q_reg[WIDTH-2:0], fits};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
`ifdef PARAM_DIVIDER_FAST_ERR_EN
                    state_next = err_in ? DONE : CALC;
`else
                    state_next = CALC;
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            CALC:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Iteration datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg       <= '0;
            shift_reg   <= '0;
            lo_reg      <= '0;
            divisor_reg <= '0;
            q_reg       <= '0;
            cnt_reg     <= '0;
            ovf_reg     <= 1'b0;
            dz_reg      <= 1'b0;
        end else if (accept) begin
            r_reg       <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
            shift_reg   <= dividend[WIDTH-1:0];
            lo_reg      <= dividend[WIDTH-1:0];
            divisor_reg <= divisor;
            q_reg       <= '0;
            cnt_reg     <= '0;
            ovf_reg     <= err_in;
            dz_reg      <= dz_in;
        end else if (state_reg == CALC) begin
            r_reg       <= r_step;
            shift_reg   <= shift_reg << 1;
            q_reg       <= q_step;
            cnt_reg     <= cnt_reg + CW'(1);
        end
    end

    // Result registers hold until a new result replaces them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            overflow_reg    <= 1'b0;
            div_by_zero_reg <= 1'b0;
        end else if (accept) begin
`ifdef PARAM_DIVIDER_FAST_ERR_EN
            if (err_in) begin
                quotient_reg    <= '1;
                remainder_reg   <= dividend[WIDTH-1:0];
                overflow_reg    <= 1'b1;
                div_by_zero_reg <= dz_in;
            end
`endif
        end else if ((state_reg == CALC) && last_step) begin
            if (ovf_reg) begin
                quotient_reg    <= '1;
                remainder_reg   <= lo_reg;
                overflow_reg    <= 1'b1;
                div_by_zero_reg <= dz_reg;
            end else begin
                quotient_reg    <= q_step;
                remainder_reg   <= r_step[WIDTH-1:0];
                overflow_reg    <= 1'b0;
                div_by_zero_reg <= 1'b0;
            end
        end
    end

    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign overflow    = overflow_reg;
    assign div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_param_divider.sv
// Randomized self-checking bench for param_divider against an arithmetic reference model.
module tb_param_divider;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [2*W-1:0] dividend = '0;
    logic [W-1:0]   divisor = '0;
    logic           busy;
    logic           done;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           overflow;
    logic           div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;

    param_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division with the error rule on the high half.
    task automatic model(input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic ov, output logic dz, output int done_at);
        int unsigned num;
        int unsigned den;
        num = dd;
        den = dv;
        dz  = (den == 0);
        ov  = dz || ((num >> W) >= den);
        if (ov) begin
            q = '1;
            r = dd[W-1:0];
        end else begin
            q = W'(num / den);
            r = W'(num % den);
        end
`ifdef PARAM_DIVIDER_FAST_ERR_EN
        done_at = ov ? 1 : W + 1;
`else
        done_at = W + 1;
`endif
    endtask

    // Waits for done; returns the negedge index (1 = first negedge after the accepting edge).
    task automatic wait_done(output int k, output int busy_cnt, output logic got, input logic scramble);
        k = 0;
        busy_cnt = 0;
        got = 1'b0;
        while (k < 40 && !got) begin
            @(negedge clk);
            k++;
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                if (scramble) begin
                    dividend = 16'($urandom);
                    divisor  = 8'($urandom);
                end
            end
        end
    endtask

    task automatic run_op(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
        logic [W-1:0] eq, er;
        logic eov, edz, got;
        int exp_k, k, bc;
        model(dd, dv, eq, er, eov, edz, exp_k);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        wait_done(k, bc, got, 1'b0);
        check("done_seen", 32'(got), 32'd1);
        check("done_cycle", 32'(k), 32'(exp_k));
        check("busy_cycles", 32'(bc), 32'(exp_k - 1));
        check("busy_with_done", 32'(busy), 32'd0);
        check("quotient", 32'(quotient), 32'(eq));
        check("remainder", 32'(remainder), 32'(er));
        check("overflow", 32'(overflow), 32'(eov));
        check("div_by_zero", 32'(div_by_zero), 32'(edz));
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("quotient_hold", 32'(quotient), 32'(eq));
        check("remainder_hold", 32'(remainder), 32'(er));
        $display("op %04h / %02h -> q=%02h r=%02h ovf=%0d dz=%0d done@%0d", dd, dv, quotient, remainder,
                 overflow, div_by_zero, k);
    endtask

    initial begin
        logic got;
        int k, bc, dones;
        logic [W-1:0] a, b, rr;

        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_flags", 32'({overflow, div_by_zero}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(16'h0064, 8'd7);
        run_op(16'hFE01, 8'hFF);
        run_op(16'h1234, 8'h00);
        run_op(16'h1234, 8'h12);
        run_op(16'h0000, 8'h01);
        run_op(16'h00FF, 8'h01);

        // start held high with operands scrambled during CALC, then a back-to-back start in the done cycle
        @(negedge clk);
        dividend = 16'h0064;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        wait_done(k, bc, got, 1'b1);
        check("b2b_first_cycle", 32'(k), 32'(W + 1));
        check("b2b_first_q", 32'(quotient), 32'h0E);
        check("b2b_first_r", 32'(remainder), 32'h02);
        check("b2b_first_flags", 32'({overflow, div_by_zero}), 32'd0);
        $display("b2b first: q=%02h r=%02h done@%0d", quotient, remainder, k);
        dividend = 16'h0051;
        divisor  = 8'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(k, bc, got, 1'b0);
        check("b2b_second_cycle", 32'(k), 32'(W + 1));
        check("b2b_second_q", 32'(quotient), 32'h09);
        check("b2b_second_r", 32'(remainder), 32'h00);
        $display("b2b second: q=%02h r=%02h done@%0d", quotient, remainder, k);
        @(negedge clk);

        // reset three cycles into CALC discards the operation
        @(negedge clk);
        dividend = 16'h0064;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_quotient", 32'(quotient), 32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        check("midrst_flags", 32'({overflow, div_by_zero}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        $display("mid-calc reset: outputs cleared, activity after reset=%0d", dones);
        run_op(16'h0064, 8'd7);

        // random: products that must divide exactly, arbitrary pairs, and zero divisors
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            case ($urandom_range(0, 3))
                0: run_op(16'(a) * 16'(b), (a == 0) ? 8'd1 : a);
                1: begin
                    if (b == 0) b = 8'd1;
                    rr = 8'($urandom_range(0, b - 1));
                    run_op(16'(a) * 16'(b) + 16'(rr), b);
                end
                2: run_op(16'($urandom), 8'($urandom));
                default: run_op(16'($urandom), 8'h00);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
